inst_fetch_queue: RTL and testbench

//  Fetch-side initiator for the combinational instruction ROM. Holds the PC.

---
 rtl/ifq_pkg.sv | 24 ++
 rtl/ifq_fifo.sv | 88 ++++++++
 rtl/inst_fetch_queue.sv | 116 +++++++++++
 tb/tb_inst_fetch_queue.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// ifq_pkg: shared types and constants for the instruction fetch queue.
//   XLEN/INST_W  address and instruction widths
//   WORD_BYTES   bytes per fetched instruction word
//   HALT_OPCODE  opcode field value that stops fetch (when halt detection is built in)
//   fetch_entry_t {pc, inst} pair stored in the FIFO
package ifq_pkg;

  localparam int XLEN       = 32;
  localparam int INST_W     = 32;
  localparam int WORD_BYTES = 4;

  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // True when the word carries the halt opcode in bits [31:26].
  function automatic logic is_halt(input logic [INST_W-1:0] word);
    return (word[31:26] == HALT_OPCODE);
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t.
// Ports:
//   clk, nrst   clock and synchronous active-low reset
//   push        write push_data at the tail (ignored when full without pop)
//   push_data   entry to write
//   pop         drop the head entry (ignored when empty)
//   flush       discard all entries, pointers back to 0 (wins over push/pop)
//   head        head entry; when empty it holds the last entry popped
//   empty       no entries stored
//   count       number of stored entries, 0..DEPTH
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_r [DEPTH];
  fetch_entry_t  last_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          empty_s;
  logic          full_s;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Occupancy flags and guarded push/pop qualifiers.
  always_comb begin
    empty_s   = (count_r == {CW{1'b0}});
    full_s    = (count_r == CW'(DEPTH));
    pop_ok_s  = pop & ~empty_s;
    push_ok_s = push & (~full_s | pop_ok_s);
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (nrst && !flush && push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and the held copy of the last popped entry.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      last_r   <= '0;
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
        last_r   <= mem_r[rd_ptr_r];
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // When empty the head keeps showing the last word handed out.
  always_comb begin
    head  = empty_s ? last_r : mem_r[rd_ptr_r];
    empty = empty_s;
    count = count_r;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch-side initiator for the combinational instruction ROM.
// Holds the PC, reads one word per cycle into a small FIFO and presents
// {pc, inst} to issue with a valid/ready handshake. A redirect flushes the
// FIFO and restarts fetch at the (word-aligned) redirect address.
// Build option: define IFQ_HALT_DETECT_EN to stop fetch after a word whose
// [31:26] is the halt opcode; otherwise halted is tied low.
// Ports:
//   clk, nrst        clock and synchronous active-low reset
//   rom_nrd          ROM read enable, active-low, combinational
//   rom_addr         ROM byte address (pc while reading, else 0)
//   rom_data         ROM word, valid in the cycle rom_nrd=0
//   redirect_valid   flush and restart at redirect_pc
//   redirect_pc      new fetch address, low two bits dropped
//   deq_valid        head entry valid
//   deq_ready        issue takes the head this cycle
//   deq_inst/deq_pc  head instruction word and its byte address
//   halted           fetch stopped on halt opcode
module inst_fetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          ROM_BYTES = 100
) (
  input  logic              clk,
  input  logic              nrst,
  output logic              rom_nrd,
  output logic [XLEN-1:0]   rom_addr,
  input  logic [INST_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [INST_W-1:0] deq_inst,
  output logic [XLEN-1:0]   deq_pc,
  output logic              halted
);

  localparam int CW = $clog2(DEPTH) + 1;
  // Highest pc whose full word still lies inside the ROM.
  localparam logic [XLEN-1:0] LAST_PC = XLEN'(ROM_BYTES - WORD_BYTES);

  logic [XLEN-1:0] pc_r;
  logic            halted_s;
  logic            empty_s;
  logic [CW-1:0]   count_s;
  fetch_entry_t    head_s;
  fetch_entry_t    push_entry_s;
  logic            deq_valid_s;
  logic            deq_fire_s;
  logic            fetch_ok_s;

  // Handshake and fetch qualification; a redirect blocks both sides.
  always_comb begin
    deq_valid_s  = nrst & ~empty_s & ~redirect_valid;
    deq_fire_s   = deq_valid_s & deq_ready;
    fetch_ok_s   = nrst & ~redirect_valid & ~halted_s & (pc_r <= LAST_PC)
                 & ((count_s < CW'(DEPTH)) | deq_fire_s);
    push_entry_s = '{pc: pc_r, inst: rom_data};
  end

  // Output drive: ROM side is combinational from state, issue side from the FIFO head.
  always_comb begin
    rom_nrd   = ~fetch_ok_s;
    rom_addr  = fetch_ok_s ? pc_r : {XLEN{1'b0}};
    deq_valid = deq_valid_s;
    deq_inst  = head_s.inst;
    deq_pc    = head_s.pc;
    halted    = halted_s;
  end

  // Program counter: reset, redirect (word aligned), or advance on each fetch.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      pc_r <= RESET_PC;
    end else if (redirect_valid) begin
      pc_r <= redirect_pc & 32'hFFFF_FFFC;
    end else if (fetch_ok_s) begin
      pc_r <= pc_r + 32'd4;
    end
  end

`ifdef IFQ_HALT_DETECT_EN
  logic halted_r;

  // Halt flag: set with the enqueue of a halt word, cleared by redirect or reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      halted_r <= 1'b0;
    end else if (redirect_valid) begin
      halted_r <= 1'b0;
    end else if (fetch_ok_s && is_halt(rom_data)) begin
      halted_r <= 1'b1;
    end
  end

  assign halted_s = halted_r;
`else
  assign halted_s = 1'b0;
`endif

  ifq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (fetch_ok_s),
    .push_data (push_entry_s),
    .pop       (deq_fire_s),
    .flush     (redirect_valid),
    .head      (head_s),
    .empty     (empty_s),
    .count     (count_s)
  );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue: directed scenarios followed by randomized
// traffic, every cycle compared against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int          DEPTH     = 4;
  localparam logic [31:0] RESET_PC  = 32'd0;
  localparam int          ROM_BYTES = 100;

  logic        clk;
  logic        nrst;
  logic        rom_nrd;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;
  logic        halted;

  logic [31:0] rom [0:31];

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] q_pc[$];
  logic [31:0] q_inst[$];
  logic [31:0] m_pc = RESET_PC;
  logic        m_halted = 1'b0;
  logic        e_fetch;
  logic        e_valid;
  logic        e_fire;

  // samples of the last stepped cycle
  logic        s_nrd, s_valid, s_halted;
  logic [31:0] s_addr, s_pc, s_inst;
  int          n_fetch;
  logic [31:0] last_fetch_addr;

  inst_fetch_queue #(
    .DEPTH(DEPTH), .RESET_PC(RESET_PC), .ROM_BYTES(ROM_BYTES)
  ) dut (
    .clk(clk), .nrst(nrst), .rom_nrd(rom_nrd), .rom_addr(rom_addr),
    .rom_data(rom_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_inst(deq_inst), .deq_pc(deq_pc), .halted(halted)
  );

  // combinational ROM, out-of-range reads return a marker word
  assign rom_data = (rom_addr < 32'd100) ? rom[rom_addr[6:2]] : 32'hDEAD_BEEF;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a < 32'd100) return rom[a[6:2]];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 32; i++) rom[i] = (i + 1) * 32'h1111_1111;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic n, input logic r, input logic [31:0] rp, input logic rdy);
    logic [31:0] w;
    nrst = n; redirect_valid = r; redirect_pc = rp; deq_ready = rdy;
    @(negedge clk);
    e_valid = n && (q_pc.size() != 0) && !r;
    e_fire  = e_valid && rdy;
    e_fetch = n && !r && !m_halted && (m_pc <= 32'(ROM_BYTES - 4))
              && ((q_pc.size() < DEPTH) || e_fire);
    s_nrd = rom_nrd; s_addr = rom_addr; s_valid = deq_valid;
    s_pc = deq_pc; s_inst = deq_inst; s_halted = halted;
    check("rom_nrd", 64'(s_nrd), 64'(!e_fetch));
    check("rom_addr", 64'(s_addr), 64'(e_fetch ? m_pc : 32'd0));
    check("deq_valid", 64'(s_valid), 64'(e_valid));
    check("halted", 64'(s_halted), 64'(m_halted));
    if (e_valid) begin
      check("deq_pc", 64'(s_pc), 64'(q_pc[0]));
      check("deq_inst", 64'(s_inst), 64'(q_inst[0]));
    end
    if (!s_nrd) begin
      n_fetch++;
      last_fetch_addr = s_addr;
    end
    @(posedge clk);
    if (!n) begin
      q_pc.delete(); q_inst.delete();
      m_pc = RESET_PC; m_halted = 1'b0;
    end else if (r) begin
      q_pc.delete(); q_inst.delete();
      m_pc = rp & 32'hFFFF_FFFC; m_halted = 1'b0;
    end else begin
      if (e_fire) begin
        void'(q_pc.pop_front()); void'(q_inst.pop_front());
      end
      if (e_fetch) begin
        w = rom_word(m_pc);
        q_pc.push_back(m_pc); q_inst.push_back(w);
        m_pc = m_pc + 32'd4;
`ifdef IFQ_HALT_DETECT_EN
        if (w[31:26] == 6'b111111) m_halted = 1'b1;
`endif
      end
    end
    #1;
  endtask

  initial begin
    int deq_seen;
    logic        rn, rr, rd;
    logic [31:0] rp;
    nrst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; deq_ready = 1'b0;
    fill_pattern();

    // reset, then streaming with deq_ready=1
    step(1'b0, 1'b0, 32'd0, 1'b1);
    check("rst_nrd", 64'(s_nrd), 64'd1);
    check("rst_valid", 64'(s_valid), 64'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("first_fetch_addr", 64'(s_addr), 64'd0);
    check("first_fetch_valid", 64'(s_valid), 64'd0);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("stream0_pc", 64'(s_pc), 64'd0);
    check("stream0_inst", 64'(s_inst), 64'h1111_1111);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("stream1_pc", 64'(s_pc), 64'd4);
    check("stream1_inst", 64'(s_inst), 64'h2222_2222);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0, 1'b1);

    // back-pressure from reset: exactly DEPTH fetches, then resume at 16
    step(1'b0, 1'b0, 32'd0, 1'b0);
    n_fetch = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0, 1'b0);
    check("full_fetch_count", 64'(n_fetch), 64'(DEPTH));
    check("full_nrd", 64'(s_nrd), 64'd1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("resume_nrd", 64'(s_nrd), 64'd0);
    check("resume_addr", 64'(s_addr), 64'd16);

    // redirect to 0x23 with 3 entries queued
    step(1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 32'h23, 1'b0);
    check("redir_valid0", 64'(s_valid), 64'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    check("redir_valid1", 64'(s_valid), 64'd0);
    check("redir_addr", 64'(s_addr), 64'h20);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("redir_first_pc", 64'(s_pc), 64'h20);

    // end of ROM: fetches at 88, 92, 96 only
    step(1'b1, 1'b1, 32'd88, 1'b1);
    n_fetch = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    check("eor_fetch_count", 64'(n_fetch), 64'd3);
    check("eor_last_addr", 64'(last_fetch_addr), 64'd96);
    check("eor_drained", 64'(s_valid), 64'd0);

    // reset with a full FIFO
    step(1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    check("midrst_valid", 64'(s_valid), 64'd0);
    check("midrst_nrd", 64'(s_nrd), 64'd0);
    check("midrst_addr", 64'(s_addr), 64'(RESET_PC));

`ifdef IFQ_HALT_DETECT_EN
    // halt word at address 8
    rom[2] = 32'hFC00_0000;
    step(1'b0, 1'b0, 32'd0, 1'b1);
    n_fetch = 0; deq_seen = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 32'd0, 1'b1);
      if (s_valid) deq_seen++;
    end
    check("halt_fetch_count", 64'(n_fetch), 64'd3);
    check("halt_deq_count", 64'(deq_seen), 64'd3);
    check("halt_flag", 64'(s_halted), 64'd1);
    step(1'b1, 1'b1, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("halt_cleared", 64'(s_halted), 64'd0);
    check("halt_restart_addr", 64'(s_addr), 64'd0);
    check("halt_restart_nrd", 64'(s_nrd), 64'd0);
    fill_pattern();
`endif

    // randomized traffic
    for (int i = 0; i < 32; i++) rom[i] = $urandom;
    for (int i = 0; i < 400; i++) begin
      rn = ($urandom_range(0, 49) != 0);
      rr = ($urandom_range(0, 11) == 0);
      rp = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 120));
      rd = ($urandom_range(0, 3) != 0);
      step(rn, rr, rp, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
